deserializer: RTL and testbench

Serial-to-parallel receiver for the bit stream produced by the design's serializer. It samples one bit per `clk` cycle and assembles TO-bit words, using an alignment strobe to mark bit 0 of each frame. Completed words are presented on a valid/ready output port, with sticky error flags for overrun and misalignment. It sits at the receive end of the serial link, in the full-rate `clk` domain; the serializer's divided clocks are not used.

---
 rtl/deserializer.sv | 82 ++++++++
 tb/tb_deserializer.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/deserializer.sv
// Serial-to-parallel receiver: one bit per clk, align strobe marks bit 0, words leave on valid/ready.
// Word visible TO edges after the aligned bit is sampled; a word completed while the output is stalled is dropped and flagged.
module deserializer #(
  parameter int TO        = 256,
  parameter int LOGTO     = 8,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          data_i,
  input  logic          align_i,
  output logic [TO-1:0] data_o,
  output logic          valid_o,
  input  logic          ready_i,
  output logic          overrun_o,
  output logic          align_err_o,
  input  logic          clear_i
);

  typedef enum logic {HUNT, RUN} state_t;

  state_t           state;
  logic [LOGTO-1:0] cnt;
  logic [LOGTO-1:0] wr_pos;
  logic [LOGTO-1:0] wr_idx;
  logic             din_q;
  logic             align_q;
  logic [TO-1:0]    asm_q;
  logic [TO-1:0]    word_next;
  logic             start;
  logic             realign;
  logic             complete;
  logic             wr_en;

  always_comb begin
    start    = (state == HUNT) && align_q;
    realign  = (state == RUN) && align_q && (cnt != '0);
    // Realignment on the last bit wins over completing the word.
    complete = (state == RUN) && (&cnt) && !align_q;
    wr_en    = start || (state == RUN);
    wr_pos   = (start || realign) ? '0 : cnt;
    // TO is a power of two, so TO-1-p is the bitwise inverse of p.
    wr_idx   = LSB_FIRST ? wr_pos : ~wr_pos;
    word_next         = asm_q;
    word_next[wr_idx] = din_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= HUNT;
      cnt         <= '0;
      din_q       <= 1'b0;
      align_q     <= 1'b0;
      asm_q       <= '0;
      data_o      <= '0;
      valid_o     <= 1'b0;
      overrun_o   <= 1'b0;
      align_err_o <= 1'b0;
    end else begin
      din_q   <= data_i;
      align_q <= align_i;

      if (wr_en) asm_q <= word_next;

      if (start || realign) cnt <= LOGTO'(1);
      else if (state == RUN) cnt <= cnt + LOGTO'(1);

      if (start) state <= RUN;

      if (complete && (!valid_o || ready_i)) begin
        data_o  <= word_next;
        valid_o <= 1'b1;
      end else if (valid_o && ready_i) begin
        valid_o <= 1'b0;
      end

      overrun_o   <= (complete && valid_o && !ready_i) || (overrun_o && !clear_i);
      align_err_o <= realign || (align_err_o && !clear_i);
    end
  end

endmodule

// File: tb/tb_deserializer.sv
// Bench for deserializer at TO=8, both bit orders, against a frame-level reference model.
module tb_deserializer;
  localparam int TO = 8;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic data_i = 1'b0;
  logic align_i = 1'b0;
  logic ready_i = 1'b1;
  logic clear_i = 1'b0;

  logic [TO-1:0] data_l, data_m;
  logic valid_l, valid_m, ovr_l, ovr_m, aerr_l, aerr_m;

  always #5 clk = ~clk;

  deserializer #(.TO(TO), .LOGTO(3), .LSB_FIRST(1'b1)) dut_l (
    .clk(clk), .reset(reset), .data_i(data_i), .align_i(align_i),
    .data_o(data_l), .valid_o(valid_l), .ready_i(ready_i),
    .overrun_o(ovr_l), .align_err_o(aerr_l), .clear_i(clear_i));

  deserializer #(.TO(TO), .LOGTO(3), .LSB_FIRST(1'b0)) dut_m (
    .clk(clk), .reset(reset), .data_i(data_i), .align_i(align_i),
    .data_o(data_m), .valid_o(valid_m), .ready_i(ready_i),
    .overrun_o(ovr_m), .align_err_o(aerr_m), .clear_i(clear_i));

  int checks = 0;
  int failures = 0;

  // Reference: frame position (-1 = hunting) and the bits collected for the current frame.
  int            pos = -1;
  bit            q[$];
  logic [TO-1:0] m_data_l = '0;
  logic [TO-1:0] m_data_m = '0;
  bit            m_valid = 1'b0;
  bit            m_ovr = 1'b0;
  bit            m_aerr = 1'b0;
  bit            p_d = 1'b0;
  bit            p_a = 1'b0;

  always @(posedge clk or negedge reset) begin
    bit done, oset, aset;
    logic [TO-1:0] wl, wm;
    if (!reset) begin
      pos = -1; q.delete();
      m_data_l = '0; m_data_m = '0; m_valid = 1'b0; m_ovr = 1'b0; m_aerr = 1'b0;
      p_d = 1'b0; p_a = 1'b0;
    end else begin
      done = 1'b0; oset = 1'b0; aset = 1'b0; wl = '0; wm = '0;
      if (pos < 0) begin
        if (p_a) begin q.delete(); q.push_back(p_d); pos = 1; end
      end else if (p_a && pos != 0) begin
        aset = 1'b1; q.delete(); q.push_back(p_d); pos = 1;
      end else begin
        q.push_back(p_d);
        pos = (pos + 1) % TO;
        if (q.size() == TO) begin
          done = 1'b1;
          for (int i = 0; i < TO; i++) if (q[i]) begin wl[i] = 1'b1; wm[TO-1-i] = 1'b1; end
          q.delete();
        end
      end
      if (done) begin
        if (!m_valid || ready_i) begin m_data_l = wl; m_data_m = wm; m_valid = 1'b1; end
        else oset = 1'b1;
      end else if (m_valid && ready_i) begin
        m_valid = 1'b0;
      end
      m_ovr  = oset || (m_ovr && !clear_i);
      m_aerr = aset || (m_aerr && !clear_i);
      p_d = data_i; p_a = align_i;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic compare_all();
    check("data_lsb", 32'(data_l), 32'(m_data_l));
    check("data_msb", 32'(data_m), 32'(m_data_m));
    check("valid_lsb", 32'(valid_l), 32'(m_valid));
    check("valid_msb", 32'(valid_m), 32'(m_valid));
    check("overrun_lsb", 32'(ovr_l), 32'(m_ovr));
    check("overrun_msb", 32'(ovr_m), 32'(m_ovr));
    check("align_err_lsb", 32'(aerr_l), 32'(m_aerr));
    check("align_err_msb", 32'(aerr_m), 32'(m_aerr));
  endtask

  task automatic send(input bit d, input bit a);
    @(negedge clk);
    compare_all();
    data_i = d;
    align_i = a;
  endtask

  task automatic send_word(input logic [7:0] w, input bit al);
    for (int i = 0; i < TO; i++) send(w[i], al && (i == 0));
  endtask

  task automatic do_reset();
    @(negedge clk);
    compare_all();
    #1 reset = 1'b0;
    #1 compare_all();
    check("rst_valid", 32'(valid_l), 32'd0);
    check("rst_data", 32'(data_l), 32'd0);
    check("rst_flags", 32'({ovr_l, aerr_l, ovr_m, aerr_m}), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    data_i = 1'b0;
    align_i = 1'b0;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    reset = 1'b1;

    // Unaligned bits are discarded.
    for (int i = 0; i < 12; i++) send(bit'($urandom_range(0, 1)), 1'b0);
    check("hunt_no_valid", 32'(valid_l), 32'd0);

    // Basic frame 4D then back-to-back FF.
    send_word(8'h4D, 1'b1);
    send(1'b1, 1'b0);
    check("t1_not_early", 32'(valid_l), 32'd0);
    send(1'b1, 1'b0);
    check("t1_data_lsb", 32'(data_l), 32'h4D);
    check("t1_data_msb", 32'(data_m), 32'hB2);
    check("t1_valid", 32'(valid_l), 32'd1);
    send(1'b1, 1'b0);
    check("t1_one_cycle", 32'(valid_l), 32'd0);
    for (int i = 0; i < 5; i++) send(1'b1, 1'b0);
    send(1'b0, 1'b0);
    send(1'b0, 1'b0);
    check("t1_second_word", 32'(data_l), 32'hFF);
    check("t1_second_valid", 32'(valid_l), 32'd1);

    // Overrun with a stalled consumer, then handshake and clear.
    do_reset();
    ready_i = 1'b0;
    send_word(8'h11, 1'b1);
    send_word(8'h22, 1'b0);
    send(1'b0, 1'b0);
    send(1'b0, 1'b0);
    check("t4_hold_data", 32'(data_l), 32'h11);
    check("t4_overrun", 32'(ovr_l), 32'd1);
    ready_i = 1'b1;
    send(1'b0, 1'b0);
    check("t4_valid_drop", 32'(valid_l), 32'd0);
    clear_i = 1'b1;
    send(1'b0, 1'b0);
    clear_i = 1'b0;
    check("t4_cleared", 32'(ovr_l), 32'd0);

    // Realignment at bit position 3.
    do_reset();
    send_word(8'h4D, 1'b1);
    send(1'b1, 1'b0); send(1'b0, 1'b0); send(1'b1, 1'b0);
    send_word(8'hA5, 1'b1);
    check("t5_align_err", 32'(aerr_l), 32'd1);
    send(1'b0, 1'b0);
    send(1'b0, 1'b0);
    check("t5_realigned_data", 32'(data_l), 32'hA5);
    check("t5_realigned_valid", 32'(valid_l), 32'd1);

    // Reset mid-frame while a word is held.
    do_reset();
    ready_i = 1'b0;
    send_word(8'h4D, 1'b1);
    for (int i = 0; i < 5; i++) send(bit'($urandom_range(0, 1)), 1'b0);
    check("t6_pre_valid", 32'(valid_l), 32'd1);
    do_reset();
    ready_i = 1'b1;
    for (int i = 0; i < 15; i++) send(bit'($urandom_range(0, 1)), 1'b0);
    check("t6_no_word", 32'(valid_l), 32'd0);
    send_word(8'h3C, 1'b1);

    // Randomized traffic.
    for (int n = 0; n < 800; n++) begin
      if ($urandom_range(0, 299) == 0) do_reset();
      ready_i = ($urandom_range(0, 9) < 7);
      clear_i = ($urandom_range(0, 29) == 0);
      send(bit'($urandom_range(0, 1)), ($urandom_range(0, 15) == 0));
    end
    send(1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
